piano_key_scan: RTL and testbench
=================================

# piano_key_scan

Input stage of the piano datapath. It synchronises and debounces the seven raw note buttons and the octave button, then resolves simultaneous presses to a single one-hot note. It produces the registered `sel` / `octave` pair consumed by the note-to-7-segment decoder and the tone generator. All outputs are glitch-free and change only on `clk` edges.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 20000: consecutive cycles an input must disagree with its stable value before the stable value flips. Minimum 1. Benches override it to 4.
- `KEYS`, default 7: number of note buttons. Fixed to 7 by the package constants.

Ports:
- `clk`, input, 1: system clock.
- `rst`, input, 1: reset; synchronous, active-high.
- `key_in`, input, 7: raw, asynchronous, active-high note buttons. Bit 6 = C, 5 = D, 4 = E, 3 = F, 2 = G, 1 = A, 0 = B.
- `oct_btn`, input, 1: raw, asynchronous, active-high octave button.
- `sel`, output, 7: registered one-hot note, same bit order as `key_in`; all-zero when no note is held.
- `octave`, output, 1: registered octave flag. 0 = low, 1 = high.
- `note_valid`, output, 1: registered; equals `|sel`.
- `note_strobe`, output, 1: one-cycle pulse in the cycle `sel` first shows a new nonzero value.

## Operation
- **Per input (8 total):** a 2-flop synchroniser, then a debouncer.
  - The debouncer holds a `stable` bit and a counter of width `$clog2(DEBOUNCE_CYCLES+1)`.
  - Synchronised == stable: the counter clears to 0.
  - Synchronised != stable: the counter increments.
  - On the `DEBOUNCE_CYCLES`-th consecutive disagreeing edge, `stable` flips and the counter clears.
  - Any agreeing cycle restarts the count, so pulses or gaps shorter than `DEBOUNCE_CYCLES` are ignored.
- **Note priority:** among the stable note bits, the lowest pitch (highest bit index, C) wins. `sel` is registered from this priority encode. Releasing the winning key while others stay held moves `sel` to the next-lowest held key.
- **Octave:** `octave` toggles on each rising edge of the stable octave bit. A release does nothing. Holding the button produces exactly one toggle.
- **Strobe:** `note_strobe` = 1 in the cycle where the new `sel` is nonzero and differs from the previous `sel`. No strobe on a transition to zero. No strobe while `sel` is unchanged.
- **Reset:** on `rst`, all synchroniser flops, stable bits and counters clear. An input held through reset must be re-debounced from scratch after `rst` deasserts.

## Timing
- **Reset values:** `sel` = 7'b0000000, `octave` = 0, `note_valid` = 0, `note_strobe` = 0. All take effect at the first edge with `rst` = 1.
- **Press latency:** raw input high at edge 0 → `sel` updated after edge `DEBOUNCE_CYCLES`+2. With D = 4, that is edge 6 and visible in cycle 7.
  - `note_valid` and `note_strobe` update on the same edge as `sel`.
  - `octave` toggles with the same latency after an `oct_btn` press.
- **Release latency** is identical: `DEBOUNCE_CYCLES`+3 cycles.
- **Simultaneous events:**
  - Two keys that stabilise on the same edge resolve by priority in one step; `sel` never shows an intermediate value.
  - A note change and an octave toggle on the same edge are both applied on that edge.
- **Rapid bounce:** any alternation with a period below `DEBOUNCE_CYCLES` leaves every output unchanged.
- **`rst` asserted mid-debounce:** the count is lost; no partial state survives.
- **Counter:** the counter saturates logically; it never wraps, because it clears on the flip.

## Structure
- **Shared package `piano_pkg`:**
  - `KEYS` = 7.
  - One-hot note constants `NOTE_C` = 7'b1000000 … `NOTE_B` = 7'b0000001, and `NOTE_NONE` = 7'b0000000. The downstream decoder uses the same constants.
  - Default `DEBOUNCE_CYCLES`.
- **Sub-module `key_debounce`:** synchroniser, counter and stable bit for one input. Parameter `DEBOUNCE_CYCLES`; ports `clk`, `rst`, `raw`, `stable`. It is instantiated 8 times (generate loop for notes, plus one for the octave button).
- **Top level contains:** the priority encoder, the `sel` / `note_valid` / `note_strobe` registers, and the octave edge-detect and toggle flop.

## Test plan
(All scenarios use `DEBOUNCE_CYCLES` = 4.)
- **Reset:** hold `rst` with `key_in` = 7'h7F, `oct_btn` = 1 → all outputs 0. After release, `sel` = 7'b1000000 exactly 7 cycles later, with one `note_strobe` pulse.
- **Single press:** `key_in` = 7'b0000100 held → `sel` = 7'b0000100, `note_valid` = 1 and one strobe after 7 cycles. Release → `sel` = 0 after 7 cycles, no strobe.
- **Bounce:** toggle `key_in`[3] every 2 cycles for 40 cycles, then hold 0 → `sel` stays 0 and no strobe throughout.
- **Priority:** hold E (7'b0010000), then add D → `sel` changes to 7'b0100000 with a strobe. Release D → `sel` returns to 7'b0010000 with a strobe.
- **Octave:** press `oct_btn` three times, each held 10 cycles with 10-cycle gaps → `octave` sequence 1, 0, 1, each toggle 7 cycles after its press. Holding 50 cycles gives a single toggle.
- **Reset mid-debounce:** raise `key_in`[0], assert `rst` for 1 cycle at cycle 3 → `sel` = 7'b0000001 only 7 cycles after `rst` drops.

Source files
------------

// File: rtl/piano_pkg.sv
// piano_pkg: note constants, default debounce length and the lowest-pitch-wins priority encode
package piano_pkg;
  localparam int KEYS = 7;
  localparam int DEBOUNCE_DEFAULT = 20000;
  localparam logic [KEYS-1:0] NOTE_C = 7'b1000000;
  localparam logic [KEYS-1:0] NOTE_D = 7'b0100000;
  localparam logic [KEYS-1:0] NOTE_E = 7'b0010000;
  localparam logic [KEYS-1:0] NOTE_F = 7'b0001000;
  localparam logic [KEYS-1:0] NOTE_G = 7'b0000100;
  localparam logic [KEYS-1:0] NOTE_A = 7'b0000010;
  localparam logic [KEYS-1:0] NOTE_B = 7'b0000001;
  localparam logic [KEYS-1:0] NOTE_NONE = 7'b0000000;
  function automatic logic [KEYS-1:0] prio(input logic [KEYS-1:0] k);
    logic [KEYS-1:0] p;
    p = NOTE_NONE;
    for (int i = 0; i < KEYS; i++) p = k[i] ? KEYS'(1) << i : p;
    return p;
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchroniser + debouncer (clk, rst, raw in, stable out)
module key_debounce import piano_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable
);
  localparam int W = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync_q, sync_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic stable_q, stable_d, hit;
  always_comb begin
    sync_d = {sync_q[0], raw};
    hit = cnt_q == W'(DEBOUNCE_CYCLES - 1);
    cnt_d = (sync_q[1] == stable_q || hit) ? '0 : cnt_q + 1'b1;
    stable_d = stable_q ^ (sync_q[1] != stable_q && hit);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      stable_q <= stable_d;
    end
  end
  assign stable = stable_q;
endmodule

// File: rtl/piano_key_scan.sv
// piano_key_scan: debounced note keys -> registered one-hot sel/note_valid/note_strobe, octave toggle flop
module piano_key_scan #(
  parameter int DEBOUNCE_CYCLES = piano_pkg::DEBOUNCE_DEFAULT,
  parameter int KEYS = piano_pkg::KEYS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [KEYS-1:0] key_in,
  input  logic            oct_btn,
  output logic [KEYS-1:0] sel,
  output logic            octave,
  output logic            note_valid,
  output logic            note_strobe
);
  logic [KEYS-1:0] key_s, sel_q, sel_d;
  logic oct_s, valid_q, valid_d, strobe_q, strobe_d, octave_q, octave_d, oct_prev_q, oct_prev_d;
  for (genvar k = 0; k < KEYS; k++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
      .clk(clk), .rst(rst), .raw(key_in[k]), .stable(key_s[k])
    );
  end
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_oct (
    .clk(clk), .rst(rst), .raw(oct_btn), .stable(oct_s)
  );
  always_comb begin
    sel_d = piano_pkg::prio(key_s);
    valid_d = |sel_d;
    strobe_d = valid_d && sel_d != sel_q;
    oct_prev_d = oct_s;
    octave_d = octave_q ^ (oct_s & ~oct_prev_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= '0;
      valid_q <= 1'b0;
      strobe_q <= 1'b0;
      octave_q <= 1'b0;
      oct_prev_q <= 1'b0;
    end else begin
      sel_q <= sel_d;
      valid_q <= valid_d;
      strobe_q <= strobe_d;
      octave_q <= octave_d;
      oct_prev_q <= oct_prev_d;
    end
  end
  assign sel = sel_q;
  assign note_valid = valid_q;
  assign note_strobe = strobe_q;
  assign octave = octave_q;
endmodule

// File: tb/tb_piano_key_scan.sv
// tb_piano_key_scan: directed self-checking bench for piano_key_scan with DEBOUNCE_CYCLES = 4
module tb_piano_key_scan;
  import piano_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] key_in = '0;
  logic oct_btn = 1'b0;
  logic [6:0] sel;
  logic octave, note_valid, note_strobe;
  int n_cmp = 0;
  int n_bad = 0;
  int n_strobe, n_tog;
  logic [6:0] sel_or;
  logic last_oct;
  piano_key_scan #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .oct_btn(oct_btn),
    .sel(sel), .octave(octave), .note_valid(note_valid), .note_strobe(note_strobe)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clr();
    n_strobe = 0;
    n_tog = 0;
    sel_or = '0;
    last_oct = octave;
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      n_strobe += int'(note_strobe);
      n_tog += int'(octave != last_oct);
      last_oct = octave;
      sel_or |= sel;
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    run(1);
    rst = 1'b0;
  endtask
  initial begin
    key_in = 7'h7F;
    oct_btn = 1'b1;
    run(3);
    chk("rst_sel", 32'(sel), 32'(NOTE_NONE));
    chk("rst_oct", 32'(octave), 0);
    chk("rst_valid", 32'(note_valid), 0);
    chk("rst_strobe", 32'(note_strobe), 0);
    rst = 1'b0;
    clr();
    run(6);
    chk("rst_rel_early", 32'(sel), 32'(NOTE_NONE));
    run(1);
    chk("rst_rel_sel", 32'(sel), 32'(NOTE_C));
    chk("rst_rel_strobe", 32'(note_strobe), 1);
    chk("rst_rel_oct", 32'(octave), 1);
    run(1);
    chk("rst_rel_strobe_off", 32'(note_strobe), 0);
    chk("rst_rel_nstrobe", 32'(n_strobe), 1);
    key_in = '0;
    oct_btn = 1'b0;
    run(8);
    chk("oct_release_noop", 32'(octave), 1);
    chk("all_release_sel", 32'(sel), 0);
    do_reset();
    chk("rst2_oct", 32'(octave), 0);
    // single press and release of G
    key_in = NOTE_G;
    clr();
    run(6);
    chk("g_early", 32'(sel), 0);
    run(1);
    chk("g_sel", 32'(sel), 32'(NOTE_G));
    chk("g_valid", 32'(note_valid), 1);
    chk("g_strobe", 32'(note_strobe), 1);
    run(1);
    chk("g_strobe_off", 32'(note_strobe), 0);
    key_in = '0;
    clr();
    run(6);
    chk("g_rel_early", 32'(sel), 32'(NOTE_G));
    run(1);
    chk("g_rel_sel", 32'(sel), 0);
    chk("g_rel_valid", 32'(note_valid), 0);
    chk("g_rel_nstrobe", 32'(n_strobe), 0);
    // bounce on F with 2-cycle half period
    clr();
    for (int i = 0; i < 20; i++) begin
      key_in[3] = ~key_in[3];
      run(2);
    end
    key_in = '0;
    run(10);
    chk("bounce_sel_or", 32'(sel_or), 0);
    chk("bounce_nstrobe", 32'(n_strobe), 0);
    // priority: E held, add D, release D
    key_in = NOTE_E;
    run(8);
    chk("prio_e", 32'(sel), 32'(NOTE_E));
    key_in = NOTE_E | NOTE_D;
    clr();
    run(8);
    chk("prio_d", 32'(sel), 32'(NOTE_D));
    chk("prio_d_nstrobe", 32'(n_strobe), 1);
    key_in = NOTE_E;
    clr();
    run(8);
    chk("prio_back_e", 32'(sel), 32'(NOTE_E));
    chk("prio_back_nstrobe", 32'(n_strobe), 1);
    key_in = '0;
    run(8);
    // simultaneous F and B from idle resolve directly to F
    key_in = NOTE_F | NOTE_B;
    clr();
    run(8);
    chk("simul_sel", 32'(sel), 32'(NOTE_F));
    chk("simul_sel_or", 32'(sel_or), 32'(NOTE_F));
    chk("simul_nstrobe", 32'(n_strobe), 1);
    key_in = '0;
    run(8);
    // octave presses: expect 1, 0, 1
    for (int p = 0; p < 3; p++) begin
      logic exp;
      exp = (p % 2 == 0);
      oct_btn = 1'b1;
      run(6);
      chk($sformatf("oct%0d_early", p), 32'(octave), 32'(!exp));
      run(1);
      chk($sformatf("oct%0d", p), 32'(octave), 32'(exp));
      run(3);
      oct_btn = 1'b0;
      run(10);
    end
    oct_btn = 1'b1;
    clr();
    run(50);
    chk("oct_hold_ntog", 32'(n_tog), 1);
    chk("oct_hold_val", 32'(octave), 0);
    oct_btn = 1'b0;
    run(10);
    // reset mid-debounce of B
    key_in = NOTE_B;
    run(3);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(6);
    chk("midrst_early", 32'(sel), 0);
    run(1);
    chk("midrst_sel", 32'(sel), 32'(NOTE_B));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
